// File: rtl/regfile_wb_scheduler_if.sv
// Write-back scheduler bundle: two write-back request ports,
// register file write port, issue check and scoreboard status.
interface regfile_wb_scheduler_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_rdest;
  logic [1:0]  a_size;
  logic [31:0] a_data;

  logic        b_valid;
  logic        b_ready;
  logic [2:0]  b_rdest;
  logic [1:0]  b_size;
  logic [31:0] b_data;

  logic        wb_we;
  logic [2:0]  wb_rdest;
  logic [1:0]  wb_size;
  logic [31:0] wb_data;

  logic        iss_valid;
  logic [2:0]  iss_rsrc1;
  logic [2:0]  iss_rsrc2;
  logic        iss_use1;
  logic        iss_use2;
  logic        iss_wr;
  logic [2:0]  iss_rdest;
  logic        iss_ready;

  logic        flush;
  logic [7:0]  busy;

  modport master (
    output a_valid, a_rdest, a_size, a_data,
    input  a_ready,
    output b_valid, b_rdest, b_size, b_data,
    input  b_ready,
    input  wb_we, wb_rdest, wb_size, wb_data,
    output iss_valid, iss_rsrc1, iss_rsrc2,
    output iss_use1, iss_use2, iss_wr, iss_rdest,
    input  iss_ready,
    output flush,
    input  busy
  );

  modport slave (
    input  a_valid, a_rdest, a_size, a_data,
    output a_ready,
    input  b_valid, b_rdest, b_size, b_data,
    output b_ready,
    output wb_we, wb_rdest, wb_size, wb_data,
    input  iss_valid, iss_rsrc1, iss_rsrc2,
    input  iss_use1, iss_use2, iss_wr, iss_rdest,
    output iss_ready,
    input  flush,
    output busy
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin write-back arbiter for the register file write port
// plus per-register pending-write scoreboard for issue stalls.
module regfile_wb_scheduler #(
  parameter int CNT_W = 2
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              last_b;
  logic              gnt_a;
  logic              gnt_b;

  logic              we_q;
  logic [2:0]        rdest_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;

  logic [CNT_W-1:0]  cnt [8];
  logic [7:0]        busy_w;
  logic [7:0]        inc_v;
  logic [7:0]        dec_v;
  logic              stall;
  logic              iss_ok;

  // Grant: lone requester wins, ties go to the port that lost last.
  always_comb begin
    gnt_a = bus.a_valid && (!bus.b_valid || last_b);
    gnt_b = bus.b_valid && (!bus.a_valid || !last_b);
  end

  assign bus.a_ready = gnt_a;
  assign bus.b_ready = gnt_b;

  // Remember last winner; reset favours A on the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

  // Register the winning write; payload holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      rdest_q <= '0;
      size_q  <= '0;
      data_q  <= '0;
    end else begin
      we_q <= gnt_a || gnt_b;
      if (gnt_a) begin
        rdest_q <= bus.a_rdest;
        size_q  <= bus.a_size;
        data_q  <= bus.a_data;
      end else if (gnt_b) begin
        rdest_q <= bus.b_rdest;
        size_q  <= bus.b_size;
        data_q  <= bus.b_data;
      end
    end
  end

  assign bus.wb_we    = we_q;
  assign bus.wb_rdest = rdest_q;
  assign bus.wb_size  = size_q;
  assign bus.wb_data  = data_q;

  // Busy comes from registered counts only, no wb_we bypass.
  always_comb begin
    busy_w = '0;
    for (int i = 0; i < 8; i++) begin
      busy_w[i] = (cnt[i] != '0);
    end
  end

  assign bus.busy = busy_w;

  // RAW on either used source, or destination counter full.
  always_comb begin
    stall = (bus.iss_use1 && busy_w[bus.iss_rsrc1])
         || (bus.iss_use2 && busy_w[bus.iss_rsrc2])
         || (bus.iss_wr && (cnt[bus.iss_rdest] == CNT_MAX));
    iss_ok = bus.iss_valid && !stall;
  end

  assign bus.iss_ready = iss_ok;

  // One-hot increment/decrement requests per register.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (iss_ok && bus.iss_wr) begin
      inc_v[bus.iss_rdest] = 1'b1;
    end
    if (we_q) begin
      dec_v[rdest_q] = 1'b1;
    end
  end

  // Pending counters: flush wins, inc+dec cancel, dec saturates at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (inc_v[i] && !dec_v[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec_v[i] && !inc_v[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench: scoreboard of expected register file writes
// and a reference pending-count model, plus directed scenarios.
module tb_regfile_wb_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler #(.CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [36:0] wb_q [$];
  logic        pend = 1'b0;
  logic        mlast = 1'b1;
  int          mcnt [8];

  // Reference model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic [36:0] e;
    logic        dv;
    logic [2:0]  dr;
    logic [7:0]  eb;
    logic        stl;
    logic        er;
    logic        ga;
    logic        gb;
    logic [2:0]  ir;
    if (!rst) begin
      wb_q.delete();
      pend  = 1'b0;
      mlast = 1'b1;
      for (int i = 0; i < 8; i++) mcnt[i] = 0;
      checks++;
      if (bus.wb_we !== 1'b0 || bus.busy !== 8'h00) begin
        errors++;
        $display("FAIL mon_reset: wb_we=%b busy=%h want 0/00",
                 bus.wb_we, bus.busy);
      end
    end else begin
      dv = 1'b0;
      dr = 3'd0;
      checks++;
      if (pend) begin
        e  = wb_q.pop_front();
        dv = 1'b1;
        dr = e[36:34];
        if (bus.wb_we !== 1'b1 ||
            {bus.wb_rdest, bus.wb_size, bus.wb_data} !== e) begin
          errors++;
          $display("FAIL mon_wb: we=%b got %h want %h", bus.wb_we,
                   {bus.wb_rdest, bus.wb_size, bus.wb_data}, e);
        end
      end else if (bus.wb_we !== 1'b0) begin
        errors++;
        $display("FAIL mon_wb_idle: wb_we=%b want 0", bus.wb_we);
      end
      for (int i = 0; i < 8; i++) eb[i] = (mcnt[i] != 0);
      checks++;
      if (bus.busy !== eb) begin
        errors++;
        $display("FAIL mon_busy: got %h want %h", bus.busy, eb);
      end
      stl = (bus.iss_use1 && eb[bus.iss_rsrc1])
         || (bus.iss_use2 && eb[bus.iss_rsrc2])
         || (bus.iss_wr && mcnt[bus.iss_rdest] == 3);
      er = bus.iss_valid && !stl;
      checks++;
      if (bus.iss_ready !== er) begin
        errors++;
        $display("FAIL mon_iss_ready: got %b want %b", bus.iss_ready, er);
      end
      ga = bus.a_valid && (!bus.b_valid || mlast);
      gb = bus.b_valid && (!bus.a_valid || !mlast);
      checks++;
      if (bus.a_ready !== ga || bus.b_ready !== gb) begin
        errors++;
        $display("FAIL mon_grant: got %b%b want %b%b",
                 bus.a_ready, bus.b_ready, ga, gb);
      end
      pend = ga || gb;
      if (ga) begin
        wb_q.push_back({bus.a_rdest, bus.a_size, bus.a_data});
        mlast = 1'b0;
      end else if (gb) begin
        wb_q.push_back({bus.b_rdest, bus.b_size, bus.b_data});
        mlast = 1'b1;
      end
      ir = bus.iss_rdest;
      if (bus.flush) begin
        for (int i = 0; i < 8; i++) mcnt[i] = 0;
      end else begin
        if (er && bus.iss_wr) mcnt[ir] = mcnt[ir] + 1;
        if (dv && mcnt[dr] > 0) mcnt[dr] = mcnt[dr] - 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.a_valid   = 1'b0;
    bus.b_valid   = 1'b0;
    bus.iss_valid = 1'b0;
    bus.iss_use1  = 1'b0;
    bus.iss_use2  = 1'b0;
    bus.iss_wr    = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [2:0] rd,
                       input logic u1, input logic [2:0] s1);
    bus.iss_valid = 1'b1;
    bus.iss_wr    = wr;
    bus.iss_rdest = rd;
    bus.iss_use1  = u1;
    bus.iss_rsrc1 = s1;
    bus.iss_use2  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.iss_valid = 1'b1;
    bus.iss_use1  = 1'b1;
    bus.iss_use2  = 1'b1;
    bus.iss_rsrc1 = 3'd3;
    bus.iss_rsrc2 = 3'd5;
    #1;
    checks++;
    if (bus.wb_we !== 1'b0 || bus.busy !== 8'h00 ||
        bus.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: we=%b busy=%h rdy=%b want 0/00/1",
               bus.wb_we, bus.busy, bus.iss_ready);
    end
    checks++;
    if (bus.wb_rdest !== 3'd0 || bus.wb_size !== 2'd0 ||
        bus.wb_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_payload: got %h want 0",
               {bus.wb_rdest, bus.wb_size, bus.wb_data});
    end
    cyc();
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    checks++;
    if (bus.wb_we !== 1'b0 || bus.busy !== 8'h00) begin
      errors++;
      $display("FAIL idle: we=%b busy=%h want 0/00",
               bus.wb_we, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rd [4];
    exp_rd[0] = 3'd1;
    exp_rd[1] = 3'd2;
    exp_rd[2] = 3'd1;
    exp_rd[3] = 3'd2;
    cyc();
    bus.a_valid = 1'b1;
    bus.a_rdest = 3'd1;
    bus.a_size  = 2'd2;
    bus.a_data  = 32'h1111_1111;
    bus.b_valid = 1'b1;
    bus.b_rdest = 3'd2;
    bus.b_size  = 2'd0;
    bus.b_data  = 32'h2222_2222;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.a_ready !== (k % 2 == 0) || bus.b_ready !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b%b", k, bus.a_ready, bus.b_ready);
      end
      if (k > 0) begin
        checks++;
        if (bus.wb_we !== 1'b1 || bus.wb_rdest !== exp_rd[k-1]) begin
          errors++;
          $display("FAIL rr_wb%0d: we=%b rd=%0d want 1/%0d", k,
                   bus.wb_we, bus.wb_rdest, exp_rd[k-1]);
        end
      end
      cyc();
    end
    idle_all();
    @(negedge clk);
    checks++;
    if (bus.wb_we !== 1'b1 || bus.wb_rdest !== 3'd2 ||
        bus.wb_data !== 32'h2222_2222) begin
      errors++;
      $display("FAIL rr_last: we=%b rd=%0d data=%h want 1/2/22222222",
               bus.wb_we, bus.wb_rdest, bus.wb_data);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.wb_we !== 1'b0 || bus.wb_data !== 32'h2222_2222) begin
      errors++;
      $display("FAIL rr_hold: we=%b data=%h want 0/22222222",
               bus.wb_we, bus.wb_data);
    end
  endtask

  task automatic test_raw();
    cyc();
    issue(1'b1, 3'd3, 1'b0, 3'd0);
    @(negedge clk);
    checks++;
    if (bus.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_issue_wr: got %b want 1", bus.iss_ready);
    end
    cyc();
    issue(1'b0, 3'd0, 1'b1, 3'd3);
    @(negedge clk);
    checks++;
    if (bus.busy !== 8'h08 || bus.iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL raw_c1: busy=%h rdy=%b want 08/0",
               bus.busy, bus.iss_ready);
    end
    cyc();
    bus.b_valid = 1'b1;
    bus.b_rdest = 3'd3;
    bus.b_size  = 2'd1;
    bus.b_data  = 32'hCAFE_0003;
    @(negedge clk);
    checks++;
    if (bus.iss_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_c2: rdy=%b b_ready=%b want 0/1",
               bus.iss_ready, bus.b_ready);
    end
    cyc();
    bus.b_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wb_we !== 1'b1 || bus.iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL raw_c3: we=%b rdy=%b want 1/0",
               bus.wb_we, bus.iss_ready);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.busy[3] !== 1'b0 || bus.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_c4: busy3=%b rdy=%b want 0/1",
               bus.busy[3], bus.iss_ready);
    end
    cyc();
    idle_all();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) begin
      cyc();
      issue(1'b1, 3'd5, 1'b0, 3'd0);
      @(negedge clk);
      checks++;
      if (bus.iss_ready !== 1'b1) begin
        errors++;
        $display("FAIL ovf_issue%0d: got %b want 1", k, bus.iss_ready);
      end
    end
    cyc();
    bus.a_valid = 1'b1;
    bus.a_rdest = 3'd5;
    bus.a_size  = 2'd3;
    bus.a_data  = 32'h5555_0005;
    @(negedge clk);
    checks++;
    if (bus.iss_ready !== 1'b0 || bus.busy[5] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: rdy=%b busy5=%b want 0/1",
               bus.iss_ready, bus.busy[5]);
    end
    cyc();
    bus.a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wb_we !== 1'b1 || bus.iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wb: we=%b rdy=%b want 1/0",
               bus.wb_we, bus.iss_ready);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (bus.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_accept: got %b want 1", bus.iss_ready);
    end
    cyc();
    idle_all();
  endtask

  task automatic test_same_cycle();
    cyc();
    issue(1'b1, 3'd4, 1'b0, 3'd0);
    cyc();
    bus.iss_valid = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_rdest = 3'd4;
    bus.a_size  = 2'd2;
    bus.a_data  = 32'h4444_0004;
    cyc();
    bus.a_valid = 1'b0;
    issue(1'b1, 3'd4, 1'b0, 3'd0);
    @(negedge clk);
    checks++;
    if (bus.wb_we !== 1'b1 || bus.wb_rdest !== 3'd4 ||
        bus.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_cyc: we=%b rd=%0d rdy=%b want 1/4/1",
               bus.wb_we, bus.wb_rdest, bus.iss_ready);
    end
    cyc();
    idle_all();
    @(negedge clk);
    checks++;
    if (bus.busy[4] !== 1'b1) begin
      errors++;
      $display("FAIL same_busy: busy4=%b want 1", bus.busy[4]);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      cyc();
      issue(1'b1, 3'd6, 1'b0, 3'd0);
    end
    cyc();
    bus.iss_valid = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy[6] !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: busy6=%b want 1", bus.busy[6]);
    end
    cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 8'h00) begin
      errors++;
      $display("FAIL flush_clear: busy=%h want 00", bus.busy);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      bus.a_valid = 1'b1;
      bus.a_rdest = 3'd6;
      bus.a_size  = 2'd2;
      bus.a_data  = 32'h6666_0000 + k;
    end
    cyc();
    bus.a_valid = 1'b0;
    cyc();
    issue(1'b0, 3'd0, 1'b1, 3'd6);
    @(negedge clk);
    checks++;
    if (bus.busy !== 8'h00 || bus.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_underflow: busy=%h rdy=%b want 00/1",
               bus.busy, bus.iss_ready);
    end
    cyc();
    idle_all();
  endtask

  task automatic test_reset_mid();
    cyc();
    bus.a_valid = 1'b1;
    bus.a_rdest = 3'd7;
    bus.a_data  = 32'h7777_7777;
    bus.b_valid = 1'b1;
    bus.b_rdest = 3'd0;
    bus.b_data  = 32'h0;
    issue(1'b1, 3'd2, 1'b0, 3'd0);
    cyc();
    cyc();
    checks++;
    if (bus.wb_we !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: we=%b want 1", bus.wb_we);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.wb_we !== 1'b0 || bus.busy !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: we=%b busy=%h want 0/00",
               bus.wb_we, bus.busy);
    end
    cyc();
    cyc();
    idle_all();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if (bus.wb_we !== 1'b0 || bus.busy !== 8'h00) begin
      errors++;
      $display("FAIL mid_after: we=%b busy=%h want 0/00",
               bus.wb_we, bus.busy);
    end
  endtask

  initial begin
    idle_all();
    bus.a_rdest   = '0;
    bus.a_size    = '0;
    bus.a_data    = '0;
    bus.b_rdest   = '0;
    bus.b_size    = '0;
    bus.b_data    = '0;
    bus.iss_rsrc1 = '0;
    bus.iss_rsrc2 = '0;
    bus.iss_rdest = '0;
    test_reset();
    test_round_robin();
    test_raw();
    test_overflow();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    cyc();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
